// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader: serial configuration-chain writer with readback and chain-length probe
module ccff_chain_loader #(
    parameter int CHAIN_LEN = 64,
    parameter int DATA_W = 8,
    localparam int CNT_W = $clog2(2*CHAIN_LEN+1)
) (
    input  logic              prog_clk,
    input  logic              prog_reset_n,
    input  logic              cmd_load,
    input  logic              cmd_probe,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic [DATA_W-1:0] rb_data,
    output logic              rb_valid,
    input  logic              rb_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              probe_ok,
    output logic [CNT_W-1:0]  probe_len,
    output logic              error
);
    localparam int NW = (CHAIN_LEN + DATA_W - 1) / DATA_W;
    localparam int WW = $clog2(NW + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LEN = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] LEN_M1 = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] LEN2_M1 = CNT_W'(2*CHAIN_LEN - 1);
    localparam logic [BW-1:0] DW = BW'(DATA_W);
    localparam logic [BW-1:0] DW_M1 = BW'(DATA_W - 1);
    localparam logic [WW-1:0] NW_C = WW'(NW);

    typedef enum logic [2:0] {IDLE, LOAD, PROBE_CLR, PROBE_RUN, DONE} state_t;
    state_t state;

    logic [DATA_W-1:0] buf_data;
    logic [BW-1:0]     buf_cnt;
    logic [BW-1:0]     asm_bits;
    logic [DATA_W-2:0] asm_q;
    logic [DATA_W-1:0] asm_w;
    logic [WW-1:0]     words;
    logic [CNT_W-1:0]  issue_cnt;
    logic [CNT_W-1:0]  shift_cnt;
    logic              prb_live;
    logic              completes;
    logic              rb_push;
    logic              can_issue;

    assign busy = state != IDLE;
    assign done = state == DONE;
    assign cfg_ready = state == LOAD && buf_cnt == '0 && words != NW_C;

    // head/shift_en are registered, so a word-completing shift may only be issued
    // when the holding register is guaranteed free on the edge it is sampled
    always_comb begin
        completes = buf_cnt == BW'(1) || issue_cnt == LEN_M1;
        rb_push = state == LOAD && ccff_shift_en && (asm_bits == DW_M1 || shift_cnt == LEN_M1);
        can_issue = buf_cnt != '0 && issue_cnt != LEN && !(completes && (rb_push || (rb_valid && !rb_ready)));
        asm_w = {asm_q, ccff_tail};
    end

    always_ff @(posedge prog_clk or negedge prog_reset_n) begin
        if (!prog_reset_n) begin
            state <= IDLE;
            buf_data <= '0;
            buf_cnt <= '0;
            asm_bits <= '0;
            asm_q <= '0;
            words <= '0;
            issue_cnt <= '0;
            shift_cnt <= '0;
            prb_live <= 1'b0;
            rb_data <= '0;
            rb_valid <= 1'b0;
            ccff_head <= 1'b0;
            ccff_shift_en <= 1'b0;
            probe_ok <= 1'b0;
            probe_len <= '0;
            error <= 1'b0;
        end else begin
            ccff_shift_en <= 1'b0;
            ccff_head <= 1'b0;
            case (state)
                IDLE: if (cmd_load || cmd_probe) begin
                    state <= cmd_load ? LOAD : PROBE_CLR;
                    error <= 1'b0;
                    probe_ok <= 1'b0;
                    probe_len <= '0;
                    issue_cnt <= '0;
                    shift_cnt <= '0;
                    words <= '0;
                    buf_cnt <= '0;
                    asm_bits <= '0;
                    prb_live <= 1'b0;
                end
                LOAD: begin
                    if (cfg_ready && cfg_valid) begin
                        buf_data <= cfg_data;
                        buf_cnt <= DW;
                        words <= words + 1'b1;
                    end
                    if (can_issue) begin
                        ccff_shift_en <= 1'b1;
                        ccff_head <= buf_data[DATA_W-1];
                        buf_data <= buf_data << 1;
                        buf_cnt <= buf_cnt - 1'b1;
                        issue_cnt <= issue_cnt + 1'b1;
                    end
                    if (ccff_shift_en) begin
                        asm_q <= asm_w[DATA_W-2:0];
                        shift_cnt <= shift_cnt + 1'b1;
                        asm_bits <= rb_push ? '0 : asm_bits + 1'b1;
                    end
                    if (rb_valid && rb_ready)
                        rb_valid <= 1'b0;
                    if (rb_push) begin
                        rb_data <= asm_w << (DW_M1 - asm_bits);
                        rb_valid <= 1'b1;
                    end
                    if (shift_cnt == LEN && rb_valid && rb_ready) begin
                        state <= DONE;
                        buf_cnt <= '0;
                    end
                end
                PROBE_CLR: begin
                    ccff_shift_en <= 1'b1;
                    issue_cnt <= issue_cnt == LEN_M1 ? '0 : issue_cnt + 1'b1;
                    state <= issue_cnt == LEN_M1 ? PROBE_RUN : PROBE_CLR;
                end
                PROBE_RUN: begin
                    ccff_shift_en <= 1'b1;
                    ccff_head <= issue_cnt == '0;
                    issue_cnt <= issue_cnt + 1'b1;
                    prb_live <= 1'b1;
                    // prb_live skips the last clearing shift still in flight on entry
                    if (prb_live && ccff_shift_en) begin
                        shift_cnt <= shift_cnt + 1'b1;
                        if (ccff_tail) begin
                            probe_len <= shift_cnt;
                            probe_ok <= shift_cnt == LEN;
                            state <= DONE;
                            ccff_shift_en <= 1'b0;
                        end else if (shift_cnt == LEN2_M1) begin
                            error <= 1'b1;
                            probe_len <= '1;
                            state <= DONE;
                            ccff_shift_en <= 1'b0;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb_ccff_chain_loader: scoreboard bench with behavioural ccff chain models (64- and 20-stage DUTs)
module tb_ccff_chain_loader;
    logic prog_clk = 1'b0;
    logic prog_reset_n = 1'b0;
    logic cmd_load_a = 1'b0, cmd_probe_a = 1'b0, cmd_load_b = 1'b0;
    logic [7:0] cfg_data = '0;
    logic cfg_valid = 1'b0, rb_ready = 1'b1;
    logic cfg_ready_a, rb_valid_a, head_a, sen_a, tail_a, busy_a, done_a, pok_a, err_a;
    logic cfg_ready_b, rb_valid_b, head_b, sen_b, tail_b, busy_b, done_b, pok_b, err_b;
    logic [7:0] rb_data_a, rb_data_b, plen_a;
    logic [5:0] plen_b;
    logic [63:0] ch_a, pre_val_a = '0;
    logic [19:0] ch_b, pre_val_b = '0;
    logic pre_a = 1'b0, pre_b = 1'b0, stuck_a = 1'b0, abort = 1'b0;
    int len_a = 64;
    int nchk = 0, nerr = 0;
    int nsh_a = 0, ndone_a = 0, nacc_a = 0, nsh_b = 0, ndone_b = 0, nacc_b = 0;
    int s_ld;
    logic [7:0] wq[$];
    logic [7:0] sb_a[$], sb_b[$];

    always #5 prog_clk = ~prog_clk;

    ccff_chain_loader #(.CHAIN_LEN(64), .DATA_W(8)) dut_a (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .cmd_load(cmd_load_a), .cmd_probe(cmd_probe_a),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_a), .rb_data(rb_data_a),
        .rb_valid(rb_valid_a), .rb_ready(rb_ready), .ccff_head(head_a), .ccff_shift_en(sen_a),
        .ccff_tail(tail_a), .busy(busy_a), .done(done_a), .probe_ok(pok_a), .probe_len(plen_a), .error(err_a));

    ccff_chain_loader #(.CHAIN_LEN(20), .DATA_W(8)) dut_b (
        .prog_clk(prog_clk), .prog_reset_n(prog_reset_n), .cmd_load(cmd_load_b), .cmd_probe(1'b0),
        .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready_b), .rb_data(rb_data_b),
        .rb_valid(rb_valid_b), .rb_ready(rb_ready), .ccff_head(head_b), .ccff_shift_en(sen_b),
        .ccff_tail(tail_b), .busy(busy_b), .done(done_b), .probe_ok(pok_b), .probe_len(plen_b), .error(err_b));

    // chain models: stage 0 takes the head, the highest used stage drives the tail
    assign tail_a = stuck_a ? 1'b0 : ch_a[len_a-1];
    assign tail_b = ch_b[19];
    always @(posedge prog_clk) begin
        if (pre_a) ch_a <= pre_val_a;
        else if (sen_a) ch_a <= {ch_a[62:0], head_a};
        if (pre_b) ch_b <= pre_val_b;
        else if (sen_b) ch_b <= {ch_b[18:0], head_b};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge prog_clk) begin
        if (sen_a) nsh_a++;
        if (sen_b) nsh_b++;
        if (done_a) ndone_a++;
        if (done_b) ndone_b++;
        if (cfg_valid && cfg_ready_a) nacc_a++;
        if (cfg_valid && cfg_ready_b) nacc_b++;
        if (rb_valid_a && rb_ready) begin
            if (sb_a.size() == 0) check("rb_a_unexpected", 64'(sb_a.size()), 1);
            else check("rb_a_word", rb_data_a, sb_a.pop_front());
        end
        if (rb_valid_b && rb_ready) begin
            if (sb_b.size() == 0) check("rb_b_unexpected", 64'(sb_b.size()), 1);
            else check("rb_b_word", rb_data_b, sb_b.pop_front());
        end
    end

    task automatic feed(input bit b, input bit gap);
        bit ok;
        for (int i = 0; i < wq.size(); i++) begin
            if (abort) return;
            if (gap && i == 4) begin
                cfg_valid = 1'b0;
                ok = 1'b0;
                for (int t = 0; t < 200 && !ok; t++) begin @(negedge prog_clk); ok = cfg_ready_a; end
                check("gap_ready", 64'(ok), 1);
                repeat (5) @(posedge prog_clk);
                #1 check("gap_shifts", 64'(nsh_a - s_ld), 32);
            end
            cfg_data = wq[i];
            cfg_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 200 && !ok && !abort; t++) begin
                @(negedge prog_clk);
                ok = b ? cfg_ready_b : cfg_ready_a;
            end
            if (!abort) check("cfg_accept", 64'(ok), 1);
            @(posedge prog_clk);
            #1;
        end
        cfg_valid = 1'b0;
    endtask

    task automatic stall_rb();
        bit seen = 1'b0;
        for (int t = 0; t < 100 && !seen; t++) begin @(negedge prog_clk); seen = rb_valid_a; end
        check("stall_rbv", 64'(seen), 1);
        repeat (10) @(posedge prog_clk);
        #1 check("stall_hold", 64'((nsh_a - s_ld) <= 15), 1);
        rb_ready = 1'b1;
    endtask

    task automatic wait_done(input bit b);
        bit seen = 1'b0;
        for (int t = 0; t < 1000 && !seen; t++) begin
            @(negedge prog_clk);
            seen = b ? done_b : done_a;
        end
        check("done_seen", 64'(seen), 1);
    endtask

    task automatic preload_a();
        pre_val_a = 64'h0123456789ABCDEF;
        pre_a = 1'b1;
        @(posedge prog_clk);
        #1 pre_a = 1'b0;
        for (int i = 0; i < 8; i++) sb_a.push_back(pre_val_a[63-8*i -: 8]);
        wq = '{8'hA5, 8'h3C, 8'h96, 8'h0F, 8'hF0, 8'h5A, 8'hC3, 8'h7E};
    endtask

    task automatic run_load(input bit gap, input bit stall, input bit both);
        int d0;
        preload_a();
        s_ld = nsh_a;
        d0 = ndone_a;
        cmd_load_a = 1'b1;
        cmd_probe_a = both;
        @(posedge prog_clk);
        #1 cmd_load_a = 1'b0;
        cmd_probe_a = 1'b0;
        if (stall) rb_ready = 1'b0;
        fork
            feed(1'b0, gap);
            begin if (stall) stall_rb(); end
        join
        wait_done(1'b0);
        check("ld_rbq_empty", 64'(sb_a.size()), 0);
        @(posedge prog_clk);
        #1 check("ld_shifts", 64'(nsh_a - s_ld), 64);
        check("ld_chain", ch_a, 64'hA53C960FF05AC37E);
        check("ld_done_once", 64'(ndone_a - d0), 1);
        check("ld_idle", 64'(busy_a), 0);
    endtask

    task automatic run_probe(input int len, input bit stk, input logic [7:0] elen, input bit eok, input bit eerr, input int esh);
        int s0 = nsh_a;
        len_a = len;
        stuck_a = stk;
        cmd_probe_a = 1'b1;
        @(posedge prog_clk);
        #1 cmd_probe_a = 1'b0;
        wait_done(1'b0);
        @(posedge prog_clk);
        #1 check("pr_len", 64'(plen_a), 64'(elen));
        check("pr_ok", 64'(pok_a), 64'(eok));
        check("pr_err", 64'(err_a), 64'(eerr));
        check("pr_shifts", 64'(nsh_a - s0), 64'(esh));
        if (len == 64 && !stk) check("pr_chain_zero", ch_a, 0);
    endtask

    initial begin
        int d0, s0;
        bit ok;
        repeat (3) @(posedge prog_clk);
        #1 prog_reset_n = 1'b1;
        cfg_valid = 1'b1;
        cfg_data = 8'h55;
        repeat (10) @(posedge prog_clk);
        #1 check("idle_outs", {cfg_ready_a, rb_data_a, rb_valid_a, head_a, sen_a, busy_a, done_a, pok_a, plen_a, err_a}, 0);
        check("idle_no_accept", 64'(nacc_a + nacc_b), 0);
        check("idle_no_shift", 64'(nsh_a + nsh_b), 0);
        cfg_valid = 1'b0;

        run_load(1'b0, 1'b0, 1'b0);
        run_load(1'b1, 1'b1, 1'b0);

        run_probe(64, 1'b1, 8'hFF, 1'b0, 1'b1, 192);
        run_probe(64, 1'b0, 8'd64, 1'b1, 1'b0, 129);
        run_probe(63, 1'b0, 8'd63, 1'b0, 1'b0, 128);
        len_a = 64;

        pre_val_b = 20'hABCDE;
        pre_b = 1'b1;
        @(posedge prog_clk);
        #1 pre_b = 1'b0;
        sb_b.push_back(8'hAB); sb_b.push_back(8'hCD); sb_b.push_back(8'hE0);
        wq = '{8'h12, 8'h34, 8'h5F};
        s0 = nacc_b; d0 = nsh_b;
        cmd_load_b = 1'b1;
        @(posedge prog_clk);
        #1 cmd_load_b = 1'b0;
        feed(1'b1, 1'b0);
        cfg_valid = 1'b1;
        cfg_data = 8'hFF;
        wait_done(1'b1);
        cfg_valid = 1'b0;
        check("b_words", 64'(nacc_b - s0), 3);
        check("b_rbq_empty", 64'(sb_b.size()), 0);
        @(posedge prog_clk);
        #1 check("b_shifts", 64'(nsh_b - d0), 20);
        check("b_chain", 64'(ch_b), 64'h12345);

        preload_a();
        s_ld = nsh_a;
        cmd_load_a = 1'b1;
        @(posedge prog_clk);
        #1 cmd_load_a = 1'b0;
        fork
            feed(1'b0, 1'b0);
            begin
                ok = 1'b0;
                for (int t = 0; t < 500 && !ok; t++) begin @(negedge prog_clk); ok = (nsh_a - s_ld) >= 30; end
                check("rst_reach30", 64'(ok), 1);
                @(posedge prog_clk);
                #1 abort = 1'b1;
                prog_reset_n = 1'b0;
                d0 = ndone_a;
                #1 check("rst_outs", {cfg_ready_a, rb_data_a, rb_valid_a, head_a, sen_a, busy_a, done_a, pok_a, plen_a, err_a}, 0);
                @(posedge prog_clk);
                #1 prog_reset_n = 1'b1;
            end
        join
        abort = 1'b0;
        cfg_valid = 1'b0;
        sb_a.delete();
        repeat (3) @(posedge prog_clk);
        #1 check("rst_no_done", 64'(ndone_a - d0), 0);
        check("rst_idle", 64'(busy_a), 0);
        run_load(1'b0, 1'b0, 1'b1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Bitstream writer for the fabric configuration chain: serializes configuration words onto `ccff_head` and collects the old contents from `ccff_tail` as readback.
- Also runs a chain-integrity probe that measures the actual chain length.
- Sits in the `prog_clk` domain at the head of a logic-tile ccff chain; its partner is the chain of configuration flops ending at `ccff_tail`.

Parameters:
- CHAIN_LEN, 64, number of ccff stages between `ccff_head` and `ccff_tail`; must be ≥2.
- DATA_W, 8, configuration/readback word width.
- CNT_W (localparam), $clog2(2*CHAIN_LEN+1), width of the shift/probe counters.

Ports:
- prog_clk  in  1  configuration clock; all logic is on the rising edge.
- prog_reset_n  in  1  asynchronous active-low reset.
- cmd_load  in  1  one-cycle pulse that starts a load.
- cmd_probe  in  1  one-cycle pulse that starts an integrity probe.
- cfg_data  in  DATA_W  configuration word, MSB shifted first.
- cfg_valid  in  1  `cfg_data` is valid.
- cfg_ready  out  1  loader accepts `cfg_data` this cycle.
- rb_data  out  DATA_W  readback word, first tail sample in the MSB.
- rb_valid  out  1  `rb_data` is valid.
- rb_ready  in  1  consumer accepts `rb_data`.
- ccff_head  out  1  serial bit into the chain (registered).
- ccff_shift_en  out  1  chain shifts on this edge (registered; gates the chain clock).
- ccff_tail  in  1  chain serial output.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse when a load or probe completes.
- probe_ok  out  1  last probe measured exactly CHAIN_LEN.
- probe_len  out  CNT_W  last measured chain length.
- error  out  1  last probe timed out; sticky until the next command.

Behaviour:
- **Reset values:** every output is 0 and the state is IDLE; chain contents are undefined. Reset mid-operation aborts immediately: no `done`, pending cfg/rb words are dropped.
- **Shift definition:** a shift is an edge with `ccff_shift_en`=1. On that edge the chain captures `ccff_head`, and the loader samples `ccff_tail`, which is the pre-shift value of the last stage.
- **States:** IDLE, LOAD, PROBE_CLR, PROBE_RUN, DONE.
- **IDLE:**
  - `cmd_load` goes to LOAD; `cmd_probe` goes to PROBE_CLR.
  - If both are high in the same cycle, load wins.
  - Both commands are ignored when not in IDLE.
  - `cfg_ready`=0.
  - Any command clears `error`.
- **LOAD, input side:** 1-word input buffer. `cfg_ready`=1 while the buffer is empty and fewer than ceil(CHAIN_LEN/DATA_W) words have been accepted.
- **LOAD, shift condition:** a shift occurs only when both hold:
  - the buffer holds a bit;
  - a readback word is not about to complete while `rb_valid`=1 and `rb_ready`=0.
- **LOAD, stalls:** otherwise `ccff_shift_en`=0 and the chain holds; no bit is lost or duplicated.
- **LOAD, bit ordering:**
  - Bits go MSB-first.
  - Shift i places data bit i on `ccff_head` and stores tail sample i into the readback shift register.
  - Every DATA_W samples form one `rb_data` word; sample 0 is in the MSB.
- **LOAD, completion:**
  - LOAD ends after exactly CHAIN_LEN shifts.
  - If CHAIN_LEN mod DATA_W ≠ 0, the unused low bits of the last cfg word are discarded.
  - The last rb word is left-aligned, with its low bits zero.
- **LOAD, done:** go to DONE once the final rb word has been accepted (`rb_valid`&`rb_ready`).
- **rb handshake:**
  - `rb_valid` stays high with `rb_data` stable until `rb_ready`.
  - Holding register plus assembly register give 1 word of slack.
  - `rb_data` is ignored by the loader in PROBE states.
- **PROBE_CLR:** CHAIN_LEN consecutive shifts of 0, no stalls, no readback.
- **PROBE_RUN:**
  - Shift 0 drives the marker 1; later shifts drive 0. k counts shifts from 0.
  - The first shift k whose tail sample is 1 sets `probe_len`=k, then go to DONE; that shift still occurs, so the chain ends all-zero.
  - Intact chain gives k=CHAIN_LEN.
  - If k reaches 2*CHAIN_LEN without a 1: `error`=1, `probe_len`=all ones, go to DONE.
  - `probe_ok` = (`probe_len`==CHAIN_LEN) & !`error`.
  - A probe destroys the configuration.
- **DONE:** `done`=1 for one cycle, then IDLE.
- **busy / hold:** `busy`=1 in LOAD, PROBE_CLR, PROBE_RUN and DONE. `probe_len`, `probe_ok` and `error` hold until the next command.

Test Plan:
1. Reset, then idle 10 cycles → all outputs 0, `cfg_ready`=0, `ccff_shift_en`=0; `cfg_valid`=1 in IDLE gets no accept.
2. CHAIN_LEN=64, DATA_W=8, chain model preloaded 0x0123456789ABCDEF (first-out bit = MSB), load 8 words 0xA5,0x3C,…
   - rb words 0x01,0x23,…,0xEF.
   - Exactly 64 shifts; the model then holds the loaded stream.
   - `done` pulses once, after the 8th rb accept.
3. Same load with `cfg_valid` low 5 cycles mid-word and `rb_ready` low 10 cycles → `ccff_shift_en` low during the gaps; final chain contents and rb words identical to scenario 2.
4. Probes:
   - 64-stage model → `probe_len`=64, `probe_ok`=1, `error`=0.
   - 63-stage model → `probe_len`=63, `probe_ok`=0.
   - Tail stuck 0 → after 128 PROBE_RUN shifts `error`=1, `probe_len`=all ones, `done` pulses.
5. CHAIN_LEN=20, DATA_W=8 → exactly 3 cfg words accepted; low 4 bits of word 3 are unused; rb word 3 has low 4 bits 0; 20 shifts total.
6. Reset asserted after 30 shifts of a load → next edge IDLE, outputs 0, no `done`; `cmd_load` and `cmd_probe` together afterwards → load runs normally.
